instr_fetch: RTL

//  Instruction fetch stage: owns the PC and issues word reads to instruction memory.

---
 rtl/instr_fetch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, one outstanding word read, skid buffer.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect traps into a FAULT state.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir_out,
    output logic [31:0] pc_out,
    output logic        ir_valid,
    output logic        fetch_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;
`endif

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid;
    logic        kill;
    logic [31:0] redir_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic redir_bad;
    logic pending;

    assign redir_tgt = redirect_pc;
    assign redir_bad = |redirect_pc[1:0];
    // A response is still owed by memory after this cycle.
    assign pending = ((state == S_REQ) && mem_gnt)
                   || ((state == S_WAIT) && !mem_rvalid)
                   || ((state == S_FAULT) && kill && !mem_rvalid);
`else
    assign redir_tgt   = redirect_pc & 32'hFFFF_FFFC;
    assign fetch_fault = 1'b0;
`endif

    // Request is a pure function of state; silenced while reset is held.
    assign mem_req  = rst_n && (state == S_REQ);
    assign mem_addr = pc;

    // Fetch FSM, PC, skid buffer and registered decode outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            skid     <= 32'h0;
            kill     <= 1'b0;
            ir_out   <= BUBBLE;
            pc_out   <= 32'h0;
            ir_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_fault <= 1'b0;
`endif
        end else if (redirect_valid) begin
            ir_out   <= BUBBLE;
            ir_valid <= 1'b0;
            pc       <= redir_tgt;
            case (state)
                S_REQ: begin
                    state <= mem_gnt ? S_WAIT : S_REQ;
                    kill  <= mem_gnt;
                end
                S_WAIT: begin
                    state <= mem_rvalid ? S_REQ : S_WAIT;
                    kill  <= !mem_rvalid;
                end
                default: begin
                    state <= S_REQ;
                    kill  <= 1'b0;
                end
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_fault <= 1'b0;
            // Leaving FAULT with a stale response due: absorb it first.
            if (state == S_FAULT && pending) begin
                state <= S_WAIT;
                kill  <= 1'b1;
            end
            if (redir_bad) begin
                state       <= S_FAULT;
                fetch_fault <= 1'b1;
                pc_out      <= redirect_pc;
                kill        <= pending;
            end
`endif
        end else begin
            if (!stall) begin
                ir_out   <= BUBBLE;
                ir_valid <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (mem_gnt) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else if (!stall) begin
                            ir_out   <= mem_rdata;
                            pc_out   <= pc;
                            ir_valid <= 1'b1;
                            pc       <= pc + 32'd4;
                            state    <= S_REQ;
                        end else begin
                            skid  <= mem_rdata;
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ir_out   <= skid;
                        pc_out   <= pc;
                        ir_valid <= 1'b1;
                        pc       <= pc + 32'd4;
                        state    <= S_REQ;
                    end
                end
                default: begin
                    if (mem_rvalid) kill <= 1'b0;
                end
            endcase
        end
    end

endmodule
